fetch_sequencer: RTL and testbench

- Control stage that sits beside the 4-bit program counter. It consumes the counter's COUNT and drives the counter's EN, WE and PC_IN.
- Holds a 16x8 program memory that is loaded in program mode.
- Runs a fetch/decode/execute FSM that latches each instruction into an instruction register, resolves jumps and issues a one-cycle execute strobe to the datapath.

---
 rtl/fetch_sequencer_pkg.sv | 43 ++++
 rtl/fetch_sequencer_prog_mem.sv | 40 ++++
 rtl/fetch_sequencer.sv | 139 +++++++++++++
 tb/tb_fetch_sequencer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer slice.
//
// Contents:
//   ADDR_W / DEPTH / INSTR_W  - geometry of the program memory and instruction word
//   OP_*                      - opcode constants (upper nibble of an instruction)
//   state_t                   - sequencer FSM state encoding
//   is_jump_taken()           - branch resolution for the control-flow opcodes
package fetch_sequencer_pkg;

    localparam int ADDR_W  = 4;
    localparam int DEPTH   = 1 << ADDR_W;
    localparam int INSTR_W = 8;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_JMP   = 4'h1;
    localparam logic [3:0] OP_JZ    = 4'h2;
    localparam logic [3:0] OP_JNZ   = 4'h3;
    localparam logic [3:0] OP_DP_LO = 4'h4;
    localparam logic [3:0] OP_DP_HI = 4'hE;
    localparam logic [3:0] OP_HALT  = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_EXECUTE = 3'd3,
        ST_HALT    = 3'd4
    } state_t;

    // JMP is unconditional; JZ/JNZ look at the datapath zero flag.
    // Everything else simply falls through to the next address.
    function automatic logic is_jump_taken(input logic [3:0] opcode, input logic zero);
        logic taken;
        case (opcode)
            OP_JMP:  taken = 1'b1;
            OP_JZ:   taken = zero;
            OP_JNZ:  taken = ~zero;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/fetch_sequencer_prog_mem.sv
// Program memory for the fetch sequencer: DEPTH x INSTR_W words.
//
// Ports:
//   clk      - rising-edge clock
//   wr_en    - write strobe (already qualified with program mode by the caller)
//   wr_addr  - write address
//   wr_data  - write data
//   rd_en    - load the read register from rd_addr on this edge
//   rd_addr  - read address
//   rd_data  - registered read data; holds its value while rd_en is low
//
// There is deliberately no reset: the contents and the read register must
// survive a sequencer reset.
module prog_mem
    import fetch_sequencer_pkg::*;
(
    input  logic               clk,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [INSTR_W-1:0] wr_data,
    input  logic               rd_en,
    input  logic [ADDR_W-1:0]  rd_addr,
    output logic [INSTR_W-1:0] rd_data
);

    logic [INSTR_W-1:0] mem [DEPTH];

    // Synchronous write port plus a read register that only updates when
    // the sequencer fetches, so the word stays stable through decode and
    // execute.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch/decode/execute control stage sitting beside a 4-bit program counter.
//
// Ports:
//   clk        - rising-edge clock
//   reset_n    - asynchronous active-low reset
//   prgm       - program mode: memory writable, sequencing suspended
//   prg_addr   - program-mode write address (also steers the counter)
//   prg_data   - program-mode write data
//   prg_wr     - memory write strobe, honoured only while prgm=1
//   run        - level, 1 = execute the program
//   pc_count   - current program counter value
//   zero       - datapath zero flag for conditional jumps
//   pc_en      - increment request to the program counter
//   pc_we      - load request to the program counter
//   pc_target  - load value for the program counter
//   ir         - instruction register
//   opcode     - ir[7:4]
//   operand    - ir[3:0]
//   exec       - one-cycle strobe telling the datapath to perform opcode
//   busy       - FSM is in FETCH, DECODE or EXECUTE
//   halted     - FSM is in HALT
module fetch_sequencer
    import fetch_sequencer_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               prgm,
    input  logic [ADDR_W-1:0]  prg_addr,
    input  logic [INSTR_W-1:0] prg_data,
    input  logic               prg_wr,
    input  logic               run,
    input  logic [ADDR_W-1:0]  pc_count,
    input  logic               zero,
    output logic               pc_en,
    output logic               pc_we,
    output logic [ADDR_W-1:0]  pc_target,
    output logic [INSTR_W-1:0] ir,
    output logic [3:0]         opcode,
    output logic [3:0]         operand,
    output logic               exec,
    output logic               busy,
    output logic               halted
);

    state_t             state;
    state_t             state_next;
    logic               jump_taken;
    logic               ir_valid;
    logic               fetch_now;
    logic [INSTR_W-1:0] mem_q;

    // An aborted fetch (program mode) must not load the instruction register.
    assign fetch_now = (state == ST_FETCH) && !prgm;

    prog_mem u_prog_mem (
        .clk     (clk),
        .wr_en   (prgm && prg_wr),
        .wr_addr (prg_addr),
        .wr_data (prg_data),
        .rd_en   (fetch_now),
        .rd_addr (pc_count),
        .rd_data (mem_q)
    );

    // The memory read register has no reset, so the visible IR is masked to
    // zero until the first fetch after reset. Reset clears the mask
    // asynchronously, which makes IR drop to zero immediately.
    assign ir      = ir_valid ? mem_q : '0;
    assign opcode  = ir[7:4];
    assign operand = ir[3:0];

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Branch decision is captured in DECODE so that EXECUTE drives the
    // counter from registered state only. ir_valid marks that the read
    // register holds a real instruction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            jump_taken <= 1'b0;
            ir_valid   <= 1'b0;
        end else begin
            if (state == ST_DECODE) begin
                jump_taken <= is_jump_taken(opcode, zero);
            end
            if (fetch_now) begin
                ir_valid <= 1'b1;
            end
        end
    end

    // Next-state logic. Program mode wins over everything and parks the
    // FSM in IDLE, abandoning whatever instruction was in flight.
    always_comb begin
        state_next = state;
        if (prgm) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:    if (run) state_next = ST_FETCH;
                ST_FETCH:   state_next = ST_DECODE;
                ST_DECODE:  state_next = (opcode == OP_HALT) ? ST_HALT : ST_EXECUTE;
                ST_EXECUTE: state_next = run ? ST_FETCH : ST_IDLE;
                ST_HALT:    if (!run) state_next = ST_IDLE;
                default:    state_next = ST_IDLE;
            endcase
        end
    end

    // Output decode. Everything is Moore except the program-mode override,
    // which makes the counter follow prg_addr combinationally. pc_en is
    // suppressed under that override so increment and load never coincide.
    always_comb begin
        exec      = (state == ST_EXECUTE);
        busy      = (state == ST_FETCH) || (state == ST_DECODE) || (state == ST_EXECUTE);
        halted    = (state == ST_HALT);
        pc_en     = 1'b0;
        pc_we     = 1'b0;
        pc_target = '0;
        if (prgm) begin
            pc_we     = 1'b1;
            pc_target = prg_addr;
        end else if (state == ST_EXECUTE) begin
            if (jump_taken) begin
                pc_we     = 1'b1;
                pc_target = operand;
            end else begin
                pc_en = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Testbench for fetch_sequencer: a behavioural program-counter model drives
// pc_count, an instruction-level reference model predicts every EXEC strobe
// into a scoreboard queue, and a monitor checks each strobe as it appears.
module tb_fetch_sequencer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       prgm;
    logic [3:0] prg_addr;
    logic [7:0] prg_data;
    logic       prg_wr;
    logic       run;
    logic [3:0] pc_count;
    logic       zero;
    logic       pc_en;
    logic       pc_we;
    logic [3:0] pc_target;
    logic [7:0] ir;
    logic [3:0] opcode;
    logic [3:0] operand;
    logic       exec;
    logic       busy;
    logic       halted;

    typedef struct packed {
        logic [7:0] instr;
        logic       taken;
        logic [3:0] target;
    } exp_t;

    int         total = 0;
    int         bad = 0;
    logic [7:0] refMem [16];
    exp_t       expQ [$];
    logic [3:0] pc;
    logic       pcForce = 1'b0;
    logic [3:0] pcForceVal = 4'h0;

    assign pc_count = pc;

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .prgm      (prgm),
        .prg_addr  (prg_addr),
        .prg_data  (prg_data),
        .prg_wr    (prg_wr),
        .run       (run),
        .pc_count  (pc_count),
        .zero      (zero),
        .pc_en     (pc_en),
        .pc_we     (pc_we),
        .pc_target (pc_target),
        .ir        (ir),
        .opcode    (opcode),
        .operand   (operand),
        .exec      (exec),
        .busy      (busy),
        .halted    (halted)
    );

    // Program counter beside the sequencer: load wins over increment; the
    // bench can also force a start address directly.
    always @(posedge clk) begin
        if (pcForce) pc <= pcForceVal;
        else if (pc_we) pc <= pc_target;
        else if (pc_en) pc <= pc + 4'd1;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Monitor: every EXEC strobe must match the oldest predicted instruction.
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            checkOutput("en_we_exclusive", {31'b0, pc_en & pc_we}, 32'd0);
            if (exec === 1'b1) begin
                checkOutput("exec_expected", {31'b0, expQ.size() != 0}, 32'd1);
                if (expQ.size() != 0) begin
                    exp_t e;
                    e = expQ.pop_front();
                    checkOutput("exec_ir", {24'b0, ir}, {24'b0, e.instr});
                    checkOutput("exec_opcode", {28'b0, opcode}, {28'b0, e.instr[7:4]});
                    checkOutput("exec_pc_we", {31'b0, pc_we}, {31'b0, e.taken});
                    checkOutput("exec_pc_en", {31'b0, pc_en}, {31'b0, ~e.taken});
                    if (e.taken) checkOutput("exec_target", {28'b0, pc_target}, {28'b0, e.target});
                end
            end
        end
    end

    // Instruction-level reference: walk up to k instructions from startPc,
    // queueing each one that executes, stopping at the first HALT.
    task automatic modelRun(input logic [3:0] startPc, input int k, input logic z,
                            output bit willHalt, output logic [3:0] endPc);
        logic [3:0] p;
        logic [7:0] ins;
        exp_t       e;
        p = startPc;
        willHalt = 0;
        for (int i = 0; i < k; i++) begin
            ins = refMem[p];
            if (ins[7:4] == 4'hF) begin
                willHalt = 1;
                break;
            end
            e.instr  = ins;
            e.target = ins[3:0];
            case (ins[7:4])
                4'h1:    e.taken = 1'b1;
                4'h2:    e.taken = z;
                4'h3:    e.taken = ~z;
                default: e.taken = 1'b0;
            endcase
            expQ.push_back(e);
            p = e.taken ? ins[3:0] : p + 4'd1;
        end
        endPc = p;
    endtask

    task automatic writeMem(input logic [3:0] addr, input logic [7:0] data);
        prgm     = 1'b1;
        prg_wr   = 1'b1;
        prg_addr = addr;
        prg_data = data;
        @(posedge clk);
        @(negedge clk);
        prg_wr = 1'b0;
        refMem[addr] = data;
    endtask

    task automatic endProgram();
        prgm = 1'b0;
        @(negedge clk);
    endtask

    task automatic setPc(input logic [3:0] v);
        pcForce    = 1'b1;
        pcForceVal = v;
        @(posedge clk);
        @(negedge clk);
        pcForce = 1'b0;
    endtask

    // One run: k instructions take 3 cycles each after the IDLE->FETCH edge,
    // so after 3k edges the k-th instruction is in EXECUTE (or we are halted).
    task automatic applyStimulus(input logic [3:0] startPc, input int k, input logic z);
        bit         willHalt;
        logic [3:0] endPc;
        setPc(startPc);
        zero = z;
        modelRun(startPc, k, z, willHalt, endPc);
        run = 1'b1;
        repeat (3 * k) @(posedge clk);
        @(negedge clk);
        checkOutput("run_halted", {31'b0, halted}, {31'b0, willHalt});
        checkOutput("run_busy", {31'b0, busy}, {31'b0, ~willHalt});
        run = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("idle_busy", {31'b0, busy}, 32'd0);
        checkOutput("idle_halted", {31'b0, halted}, 32'd0);
        checkOutput("final_pc", {28'b0, pc}, {28'b0, endPc});
        checkOutput("queue_drained", expQ.size(), 32'd0);
    endtask

    // Safety net so the bench always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n  = 1'b0;
        prgm     = 1'b0;
        prg_wr   = 1'b0;
        prg_addr = 4'h0;
        prg_data = 8'h00;
        run      = 1'b0;
        zero     = 1'b0;
        #1;
        checkOutput("rst_exec", {31'b0, exec}, 32'd0);
        checkOutput("rst_pc_en", {31'b0, pc_en}, 32'd0);
        checkOutput("rst_pc_we", {31'b0, pc_we}, 32'd0);
        checkOutput("rst_busy", {31'b0, busy}, 32'd0);
        checkOutput("rst_halted", {31'b0, halted}, 32'd0);
        checkOutput("rst_ir", {24'b0, ir}, 32'd0);
        checkOutput("rst_target", {28'b0, pc_target}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Straight-line program ending in HALT.
        writeMem(4'h0, 8'h40);
        writeMem(4'h1, 8'h41);
        writeMem(4'h2, 8'hF0);
        writeMem(4'h3, 8'h27);
        writeMem(4'h4, 8'h40);
        writeMem(4'h5, 8'h1A);
        writeMem(4'h7, 8'h40);
        writeMem(4'hA, 8'h42);
        writeMem(4'hF, 8'h40);
        endProgram();
        applyStimulus(4'h0, 3, 1'b0);

        // Unconditional jump, then the target instruction.
        applyStimulus(4'h5, 2, 1'b0);

        // JZ taken / not taken, then JNZ with the outcomes swapped.
        applyStimulus(4'h3, 1, 1'b1);
        applyStimulus(4'h3, 1, 1'b0);
        writeMem(4'h3, 8'h37);
        endProgram();
        applyStimulus(4'h3, 1, 1'b1);
        applyStimulus(4'h3, 1, 1'b0);

        // Wrap-around from the top address.
        applyStimulus(4'hF, 1, 1'b0);

        // Program mode during DECODE aborts the instruction.
        setPc(4'h0);
        run = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        prgm     = 1'b1;
        prg_addr = 4'h9;
        run      = 1'b0;
        #1;
        checkOutput("prgm_pc_we", {31'b0, pc_we}, 32'd1);
        checkOutput("prgm_target", {28'b0, pc_target}, 32'd9);
        checkOutput("prgm_pc_en", {31'b0, pc_en}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("prgm_idle_busy", {31'b0, busy}, 32'd0);
        checkOutput("prgm_counter", {28'b0, pc}, 32'd9);
        prgm = 1'b0;

        // A write strobe outside program mode must not change memory.
        prg_wr   = 1'b1;
        prg_addr = 4'h0;
        prg_data = 8'hF0;
        @(posedge clk);
        @(negedge clk);
        prg_wr = 1'b0;
        applyStimulus(4'h0, 1, 1'b0);

        // Asynchronous reset in the middle of EXECUTE.
        setPc(4'h0);
        run = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        checkOutput("midrst_exec", {31'b0, exec}, 32'd0);
        checkOutput("midrst_pc_en", {31'b0, pc_en}, 32'd0);
        checkOutput("midrst_pc_we", {31'b0, pc_we}, 32'd0);
        checkOutput("midrst_busy", {31'b0, busy}, 32'd0);
        checkOutput("midrst_ir", {24'b0, ir}, 32'd0);
        run = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        applyStimulus(4'h0, 2, 1'b0);

        // Randomized programs, start addresses, lengths and zero flag.
        for (int iter = 0; iter < 20; iter++) begin
            for (int a = 0; a < 16; a++) begin
                logic [7:0] w;
                w = 8'($urandom_range(0, 255));
                writeMem(4'(a), w);
            end
            endProgram();
            applyStimulus(4'($urandom_range(0, 15)), $urandom_range(1, 8), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
